pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the RV32 core.
- Decides, every cycle, whether the PC and IF/ID registers hold, and whether IF/ID and ID/EX are flushed.
- Handles three causes: EX-stage jumps/taken branches, load-use hazards against the operands being decoded, and an external hold request (bus/multi-cycle unit) with a req/ack handshake.
- Sits between id/ex and the pc_reg, if_id and id_ex pipeline registers.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles flush_if_id_o/flush_id_ex_o stay asserted per accepted jump (legal 1..3).
- ADDR_W, 32, jump address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_reg1_raddr_i  in  5  rs1 address being decoded (0 = unused)
- id_reg2_raddr_i  in  5  rs2 address being decoded (0 = unused)
- ex_reg_we_i  in  1  EX instruction writes rd
- ex_reg_waddr_i  in  5  EX destination register
- ex_mem_rd_i  in  1  EX instruction is a load
- ex_jump_flag_i  in  1  EX resolved jump/taken branch
- ex_jump_addr_i  in  ADDR_W  EX jump target
- hold_req_i  in  1  external hold request (level)
- hold_ack_o  out  1  pipeline held and drained
- jump_flag_o  out  1  redirect PC
- jump_addr_o  out  ADDR_W  redirect target
- hold_pc_o  out  1  PC keeps value
- hold_if_id_o  out  1  IF/ID keeps value
- flush_if_id_o  out  1  IF/ID loads NOP
- flush_id_ex_o  out  1  ID/EX loads bubble

Behaviour:
- Reset: in any cycle with rst=1, all outputs are 0 and jump_addr_o=0. Next state is RUN, flush counter is 0, perf counters are 0. Reset overrides any state mid-operation, including HOLD and FLUSH.
- States: RUN, FLUSH, HOLD (2-bit register).
- Load-use hazard is defined as: ex_mem_rd_i & ex_reg_we_i & ex_reg_waddr_i!=0 & (ex_reg_waddr_i==id_reg1_raddr_i | ex_reg_waddr_i==id_reg2_raddr_i).
- RUN priority is jump > hold request > load-use. All RUN outputs are combinational in the same cycle.
  - Jump: jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Hold request: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, hold_ack_o=0. Go to HOLD.
  - Load-use: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 for exactly this cycle; stay in RUN. The inserted bubble clears the hazard the next cycle.
  - None of the above: all outputs 0.
- FLUSH:
  - flush_if_id_o=1, flush_id_ex_o=1, jump_flag_o=0.
  - ex_jump_flag_i, hold_req_i and load-use are ignored, since EX holds a squashed instruction.
  - Counter decrements each cycle; when it reaches 1, return to RUN.
  - A hold_req_i still high is taken in RUN on the following cycle.
- HOLD:
  - hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1, hold_ack_o=1.
  - ex_jump_flag_i is ignored, since EX contains a bubble.
  - When hold_req_i=0, return to RUN next cycle; outputs in that cycle are still the HOLD values.
  - Requester may drop req only after seeing ack=1. Dropping earlier is legal: the controller still spends one HOLD cycle.
- Hold handshake timing: ack first rises the cycle after req is sampled in RUN, and falls one cycle after req falls.
- hold_pc_o and hold_if_id_o are never asserted together with jump_flag_o.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN adds three 32-bit wrapping outputs, all cleared by rst:
  - perf_stall_cnt_o: counts cycles with load-use stall asserted.
  - perf_flush_cnt_o: counts accepted jumps.
  - perf_hold_cnt_o: counts cycles in HOLD.
- Without the macro, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_rd_i=1, ex_reg_we_i=1, ex_reg_waddr_i=5, id_reg2_raddr_i=5 for one cycle -> hold_pc_o=hold_if_id_o=flush_id_ex_o=1 that cycle only, all 0 the next. Repeat with ex_reg_waddr_i=0 -> no stall.
- Jump, FLUSH_CYCLES=2: ex_jump_flag_i=1, ex_jump_addr_i=0x0000_0100 -> jump_flag_o=1, jump_addr_o=0x100, both flushes=1 in cycle T. In T+1 flushes stay 1, jump_flag_o=0, and an ex_jump_flag_i pulse is ignored. T+2 is RUN with outputs 0.
- Hold handshake: hold_req_i rises at T -> holds=1, ack=0 at T; ack=1 at T+1..T+N. Req falls at T+N -> ack=1 at T+N, all outputs 0 at T+N+1.
- Priority: ex_jump_flag_i, hold_req_i and load-use all asserted at once -> jump taken, no hold_pc_o. Next RUN cycle (FLUSH_CYCLES=1) enters hold with ack the cycle after.
- Reset mid-HOLD: rst=1 for one cycle while in HOLD with hold_req_i=1 -> all outputs 0 that cycle. Next cycle re-enters hold with ack=0, then ack=1 one cycle later.
- PIPE_CTRL_PERF_EN: 3 load-use stalls, 2 jumps, 4 HOLD cycles -> perf_stall_cnt_o=3, perf_flush_cnt_o=2, perf_hold_cnt_o=4. All counters read 0 after rst.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the RV32 core. It decides each
// cycle whether PC and IF/ID hold and whether IF/ID and ID/EX are flushed. The
// inputs are EX jumps, load-use hazards against decode operands, and an external hold request.
// Latency: RUN-state decisions are combinational in the same cycle. FLUSH and
// HOLD span later cycles and are tracked by a 2-bit state register.
// Backpressure: hold_req/hold_ack level handshake. ack rises the cycle after req
// is sampled in RUN and falls one cycle after req falls.
// Ports:
//   clk, rst                        core clock, synchronous active-high reset
//   id_reg1_raddr_i/id_reg2_raddr_i decode-stage source registers (0 = unused)
//   ex_reg_we_i/ex_reg_waddr_i/ex_mem_rd_i  EX destination info for load-use
//   ex_jump_flag_i/ex_jump_addr_i   EX resolved redirect
//   hold_req_i/hold_ack_o           external hold handshake
//   jump_flag_o/jump_addr_o         PC redirect
//   hold_pc_o/hold_if_id_o          stage holds
//   flush_if_id_o/flush_id_ex_o     stage flushes
// Optional: define PIPE_CTRL_PERF_EN to add perf_stall_cnt_o, perf_flush_cnt_o
// and perf_hold_cnt_o. These are 32-bit wrapping counters cleared by rst.

module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_reg1_raddr_i,
  input  logic [4:0]        id_reg2_raddr_i,
  input  logic              ex_reg_we_i,
  input  logic [4:0]        ex_reg_waddr_i,
  input  logic              ex_mem_rd_i,
  input  logic              ex_jump_flag_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              hold_req_i,
  output logic              hold_ack_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_pc_o,
  output logic              hold_if_id_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o,
  output logic [31:0]       perf_hold_cnt_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Number of FLUSH-state cycles that follow the jump cycle itself.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] flush_cnt;
  logic [1:0] flush_cnt_nxt;

  logic load_use;
  logic jump_evt;
  logic stall_evt;

  logic              ack_c;
  logic              jump_c;
  logic [ADDR_W-1:0] jaddr_c;
  logic              hpc_c;
  logic              hifid_c;
  logic              fifid_c;
  logic              fidex_c;

  assign load_use = ex_mem_rd_i & ex_reg_we_i & (ex_reg_waddr_i != 5'd0) &
                    ((ex_reg_waddr_i == id_reg1_raddr_i) |
                     (ex_reg_waddr_i == id_reg2_raddr_i));

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    jump_evt      = 1'b0;
    stall_evt     = 1'b0;
    ack_c         = 1'b0;
    jump_c        = 1'b0;
    jaddr_c       = '0;
    hpc_c         = 1'b0;
    hifid_c       = 1'b0;
    fifid_c       = 1'b0;
    fidex_c       = 1'b0;

    case (state)
      ST_RUN: begin
        if (ex_jump_flag_i) begin
          jump_evt = 1'b1;
          jump_c   = 1'b1;
          jaddr_c  = ex_jump_addr_i;
          fifid_c  = 1'b1;
          fidex_c  = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_INIT;
          end
        end else if (hold_req_i) begin
          // Ack stays low here: the bubble entering ID/EX this cycle
          // must settle before the pipeline counts as drained.
          hpc_c     = 1'b1;
          hifid_c   = 1'b1;
          fidex_c   = 1'b1;
          state_nxt = ST_HOLD;
        end else if (load_use) begin
          stall_evt = 1'b1;
          hpc_c     = 1'b1;
          hifid_c   = 1'b1;
          fidex_c   = 1'b1;
        end
      end

      ST_FLUSH: begin
        // EX holds a squashed instruction, so all requests wait.
        fifid_c = 1'b1;
        fidex_c = 1'b1;
        if (flush_cnt <= 2'd1) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = 2'd0;
        end else begin
          flush_cnt_nxt = flush_cnt - 2'd1;
        end
      end

      ST_HOLD: begin
        // EX contains a bubble, so a jump flag here is stale.
        ack_c   = 1'b1;
        hpc_c   = 1'b1;
        hifid_c = 1'b1;
        fidex_c = 1'b1;
        if (!hold_req_i) begin
          state_nxt = ST_RUN;
        end
      end

      default: begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Reset forces every output low in the same cycle, not just from the next one.
  assign hold_ack_o    = rst ? 1'b0 : ack_c;
  assign jump_flag_o   = rst ? 1'b0 : jump_c;
  assign jump_addr_o   = rst ? '0   : jaddr_c;
  assign hold_pc_o     = rst ? 1'b0 : hpc_c;
  assign hold_if_id_o  = rst ? 1'b0 : hifid_c;
  assign flush_if_id_o = rst ? 1'b0 : fifid_c;
  assign flush_id_ex_o = rst ? 1'b0 : fidex_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_evt_cnt;
  logic [31:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= 32'd0;
      flush_evt_cnt <= 32'd0;
      hold_cnt      <= 32'd0;
    end else begin
      if (stall_evt)         stall_cnt     <= stall_cnt + 32'd1;
      if (jump_evt)          flush_evt_cnt <= flush_evt_cnt + 32'd1;
      if (state == ST_HOLD)  hold_cnt      <= hold_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = rst ? 32'd0 : stall_cnt;
  assign perf_flush_cnt_o = rst ? 32'd0 : flush_evt_cnt;
  assign perf_hold_cnt_o  = rst ? 32'd0 : hold_cnt;
`else
  logic unused_evt;
  assign unused_evt = stall_evt | jump_evt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. It runs three instances (FLUSH_CYCLES = 1, 2, 3)
// from shared stimulus and compares each one every cycle against a reference
// model built from the controller's rules: pending flush cycles, hold
// engagement, and the jump > hold > load-use priority.

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic        we;
  logic [4:0]  wa;
  logic        mr;
  logic        jf_in;
  logic [31:0] ja_in;
  logic        hr;

  logic [2:0]  ack;
  logic [2:0]  jf;
  logic [2:0]  hpc;
  logic [2:0]  hifid;
  logic [2:0]  fifid;
  logic [2:0]  fidex;
  logic [31:0] ja [3];
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] p_stall [3];
  logic [31:0] p_flush [3];
  logic [31:0] p_hold  [3];
`endif

  int vectors;
  int miscompares;
  int cyc;

  // Reference model state for each instance.
  int flush_left [3];
  bit holding    [3];
  int m_stall    [3];
  int m_flush    [3];
  int m_hold     [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .id_reg1_raddr_i(a1), .id_reg2_raddr_i(a2),
    .ex_reg_we_i(we), .ex_reg_waddr_i(wa), .ex_mem_rd_i(mr),
    .ex_jump_flag_i(jf_in), .ex_jump_addr_i(ja_in), .hold_req_i(hr),
    .hold_ack_o(ack[0]), .jump_flag_o(jf[0]), .jump_addr_o(ja[0]),
    .hold_pc_o(hpc[0]), .hold_if_id_o(hifid[0]),
    .flush_if_id_o(fifid[0]), .flush_id_ex_o(fidex[0])
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt_o(p_stall[0]), .perf_flush_cnt_o(p_flush[0]),
    .perf_hold_cnt_o(p_hold[0])
`endif
  );

  pipe_ctrl #(.FLUSH_CYCLES(2), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .id_reg1_raddr_i(a1), .id_reg2_raddr_i(a2),
    .ex_reg_we_i(we), .ex_reg_waddr_i(wa), .ex_mem_rd_i(mr),
    .ex_jump_flag_i(jf_in), .ex_jump_addr_i(ja_in), .hold_req_i(hr),
    .hold_ack_o(ack[1]), .jump_flag_o(jf[1]), .jump_addr_o(ja[1]),
    .hold_pc_o(hpc[1]), .hold_if_id_o(hifid[1]),
    .flush_if_id_o(fifid[1]), .flush_id_ex_o(fidex[1])
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt_o(p_stall[1]), .perf_flush_cnt_o(p_flush[1]),
    .perf_hold_cnt_o(p_hold[1])
`endif
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .id_reg1_raddr_i(a1), .id_reg2_raddr_i(a2),
    .ex_reg_we_i(we), .ex_reg_waddr_i(wa), .ex_mem_rd_i(mr),
    .ex_jump_flag_i(jf_in), .ex_jump_addr_i(ja_in), .hold_req_i(hr),
    .hold_ack_o(ack[2]), .jump_flag_o(jf[2]), .jump_addr_o(ja[2]),
    .hold_pc_o(hpc[2]), .hold_if_id_o(hifid[2]),
    .flush_if_id_o(fifid[2]), .flush_id_ex_o(fidex[2])
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt_o(p_stall[2]), .perf_flush_cnt_o(p_flush[2]),
    .perf_hold_cnt_o(p_hold[2])
`endif
  );

  // Bit order: {ack, jump_flag, hold_pc, hold_if_id, flush_if_id, flush_id_ex}.
  function automatic logic [5:0] flags_of(int k);
    return {ack[k], jf[k], hpc[k], hifid[k], fifid[k], fidex[k]};
  endfunction

  function automatic logic is_load_use();
    return mr && we && (wa != 5'd0) && (wa == a1 || wa == a2);
  endfunction

  // Expected {flags, jump_addr} for instance k given model state and inputs.
  function automatic logic [37:0] expect_out(int k);
    logic [5:0]  f;
    logic [31:0] a;
    f = 6'b000000;
    a = 32'd0;
    if (rst)                f = 6'b000000;
    else if (flush_left[k] > 0) f = 6'b000011;
    else if (holding[k])    f = 6'b101101;
    else if (jf_in) begin   f = 6'b010011; a = ja_in; end
    else if (hr)            f = 6'b001101;
    else if (is_load_use()) f = 6'b001101;
    return {f, a};
  endfunction

  task automatic model_update(int k);
    if (rst) begin
      flush_left[k] = 0; holding[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0; m_hold[k] = 0;
    end else if (flush_left[k] > 0) begin
      flush_left[k]--;
    end else if (holding[k]) begin
      m_hold[k]++;
      holding[k] = hr;
    end else if (jf_in) begin
      m_flush[k]++;
      flush_left[k] = k;  // FLUSH_CYCLES - 1, with FLUSH_CYCLES = k + 1
    end else if (hr) begin
      holding[k] = 1;
    end else if (is_load_use()) begin
      m_stall[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Called shortly after inputs change at the falling edge: checks every
  // instance against the model, then advances the model to match the next rising edge.
  task automatic check_cycle();
    logic [37:0] obs;
    logic [37:0] exp;
    #1;
    for (int k = 0; k < 3; k++) begin
      obs = {flags_of(k), ja[k]};
      exp = expect_out(k);
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL model dut%0d cyc=%0d observed=%h expected=%h", k, cyc, obs, exp);
      end
`ifdef PIPE_CTRL_PERF_EN
      chk($sformatf("perf_stall dut%0d", k), p_stall[k], rst ? 32'd0 : 32'(m_stall[k]));
      chk($sformatf("perf_flush dut%0d", k), p_flush[k], rst ? 32'd0 : 32'(m_flush[k]));
      chk($sformatf("perf_hold dut%0d", k),  p_hold[k],  rst ? 32'd0 : 32'(m_hold[k]));
`endif
    end
    for (int k = 0; k < 3; k++) model_update(k);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    a1 = 5'd0; a2 = 5'd0; we = 1'b0; wa = 5'd0; mr = 1'b0;
    jf_in = 1'b0; ja_in = 32'd0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    for (int k = 0; k < 3; k++) begin
      flush_left[k] = 0; holding[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0; m_hold[k] = 0;
    end
    idle_inputs();
    hr  = 1'b0;
    rst = 1'b1;
    next_cycle();

    // Reset state
    check_cycle();
    chk("reset_flags", 32'(flags_of(1)), 32'd0);
    chk("reset_addr", ja[1], 32'd0);
    next_cycle();
    rst = 1'b0;
    check_cycle(); next_cycle();

    // Load-use on rs2 stalls for exactly one cycle
    mr = 1'b1; we = 1'b1; wa = 5'd5; a2 = 5'd5;
    check_cycle();
    chk("lu_hold_pc", 32'(hpc[1]), 32'd1);
    chk("lu_flush_id_ex", 32'(fidex[1]), 32'd1);
    next_cycle();
    idle_inputs();
    check_cycle();
    chk("lu_after", 32'(flags_of(1)), 32'd0);
    next_cycle();
    // x0 destination never stalls
    mr = 1'b1; we = 1'b1; wa = 5'd0; a1 = 5'd0; a2 = 5'd0;
    check_cycle();
    chk("lu_x0", 32'(hpc[1]), 32'd0);
    next_cycle();
    idle_inputs();

    // Jump with FLUSH_CYCLES=2; the second pulse lands in FLUSH and is ignored
    jf_in = 1'b1; ja_in = 32'h0000_0100;
    check_cycle();
    chk("jump_flag", 32'(jf[1]), 32'd1);
    chk("jump_addr", ja[1], 32'h100);
    chk("jump_flush", 32'({fifid[1], fidex[1]}), 32'd3);
    next_cycle();
    ja_in = 32'h0000_0200;
    check_cycle();
    chk("flush2_flags", 32'(flags_of(1)), 32'b000011);
    next_cycle();
    idle_inputs();
    check_cycle();
    chk("flush_done", 32'(flags_of(1)), 32'd0);
    next_cycle();
    check_cycle(); next_cycle();

    // Hold handshake held for four cycles
    hr = 1'b1;
    check_cycle();
    chk("hold_t0_ack", 32'(ack[1]), 32'd0);
    chk("hold_t0_pc", 32'(hpc[1]), 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("hold_ack_hi", 32'(ack[1]), 32'd1);
      next_cycle();
    end
    hr = 1'b0;
    check_cycle();
    chk("hold_drop_ack", 32'(ack[1]), 32'd1);
    next_cycle();
    check_cycle();
    chk("hold_release", 32'(flags_of(1)), 32'd0);
    next_cycle();

    // Priority: jump beats hold beats load-use (FLUSH_CYCLES=1 instance)
    jf_in = 1'b1; ja_in = 32'h0000_0040; hr = 1'b1;
    mr = 1'b1; we = 1'b1; wa = 5'd7; a1 = 5'd7;
    check_cycle();
    chk("prio_jump", 32'(jf[0]), 32'd1);
    chk("prio_no_hold", 32'(hpc[0]), 32'd0);
    next_cycle();
    idle_inputs();
    check_cycle();
    chk("prio_hold_ack0", 32'({ack[0], hpc[0]}), 32'b01);
    next_cycle();
    check_cycle();
    chk("prio_hold_ack1", 32'(ack[0]), 32'd1);
    next_cycle();
    hr = 1'b0;
    for (int i = 0; i < 4; i++) begin check_cycle(); next_cycle(); end

    // Reset in the middle of HOLD
    hr = 1'b1;
    check_cycle(); next_cycle();
    check_cycle(); next_cycle();
    rst = 1'b1;
    check_cycle();
    chk("rst_hold_flags", 32'(flags_of(1)), 32'd0);
    next_cycle();
    rst = 1'b0;
    check_cycle();
    chk("rst_rehold_ack0", 32'({ack[1], hpc[1]}), 32'b01);
    next_cycle();
    check_cycle();
    chk("rst_rehold_ack1", 32'(ack[1]), 32'd1);
    next_cycle();
    hr = 1'b0;
    for (int i = 0; i < 3; i++) begin check_cycle(); next_cycle(); end

    // Randomized traffic; hold request is a level that toggles occasionally
    for (int i = 0; i < 1500; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      a1    = 5'($urandom_range(0, 3));
      a2    = 5'($urandom_range(0, 3));
      wa    = 5'($urandom_range(0, 3));
      we    = 1'($urandom_range(0, 1));
      mr    = 1'($urandom_range(0, 1));
      jf_in = ($urandom_range(0, 5) == 0);
      ja_in = $urandom;
      if ($urandom_range(0, 7) == 0) hr = ~hr;
      check_cycle();
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
